// File: rtl/bitwise_alu_pipe.sv
// bitwise_alu_pipe: eight bitwise ops plus a running XOR accumulator, one registered result stage.
// Latency: result valid one cycle after acceptance; 1 beat/cycle while out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls the producer, acc updates only on accept.
// Optional: define BITWISE_ALU_PARITY_EN to add the registered out_par port (XOR reduction of out_data).
module bitwise_alu_pipe #(
  parameter int unsigned           WIDTH    = 4,
  parameter logic [WIDTH-1:0]      ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_ALU_PARITY_EN
  output logic             out_par,
`endif
  output logic             out_zero
);

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_XNOR    = 3'b011;
  localparam logic [2:0] OP_NAND    = 3'b100;
  localparam logic [2:0] OP_NOR     = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] res_d;
  logic             accept;
`ifdef BITWISE_ALU_PARITY_EN
  logic             par_q;
`endif

  // Single output register: it can take a new beat when empty or when it drains this cycle.
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign out_data  = data_q;
  assign out_zero  = zero_q;
`ifdef BITWISE_ALU_PARITY_EN
  assign out_par   = par_q;
`endif

  // Result and next-accumulator selection; acc ops return the new accumulator value so
  // a CLR followed directly by an XOR sees the cleared value through acc_q.
  always_comb begin
    res_d = '0;
    acc_d = acc_q;
    unique case (in_op)
      OP_AND:     res_d = in_x & in_y;
      OP_OR:      res_d = in_x | in_y;
      OP_XOR:     res_d = in_x ^ in_y;
      OP_XNOR:    res_d = ~(in_x ^ in_y);
      OP_NAND:    res_d = ~(in_x & in_y);
      OP_NOR:     res_d = ~(in_x | in_y);
      OP_ACC_XOR: begin
        acc_d = acc_q ^ in_x ^ in_y;
        res_d = acc_d;
      end
      OP_ACC_CLR: begin
        acc_d = ACC_INIT;
        res_d = ACC_INIT;
      end
      default:    res_d = '0;
    endcase
  end

  // EMPTY/FULL state machine with registered result, zero flag and accumulator.
  // Accumulator and result move only on accept, so stalled beats are never counted twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      zero_q  <= 1'b1;
      acc_q   <= ACC_INIT;
`ifdef BITWISE_ALU_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        state_q <= ST_FULL;
        data_q  <= res_d;
        zero_q  <= (res_d == '0);
        acc_q   <= acc_d;
`ifdef BITWISE_ALU_PARITY_EN
        par_q   <= ^res_d;
`endif
      end else if ((state_q == ST_FULL) && out_ready) begin
        state_q <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Directed bench for bitwise_alu_pipe at WIDTH=4, ACC_INIT=0.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at that same point.
// Parity checks are compiled in only when BITWISE_ALU_PARITY_EN is defined.
module tb_bitwise_alu_pipe;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;
`ifdef BITWISE_ALU_PARITY_EN
  logic         out_par;
`endif

  int errors = 0;
  int checks = 0;

  bitwise_alu_pipe #(.WIDTH(W), .ACC_INIT(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BITWISE_ALU_PARITY_EN
    .out_par   (out_par),
`endif
    .out_zero  (out_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    in_op    = op;
    in_x     = x;
    in_y     = y;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] d, input logic z);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  64'(out_data),  64'(d));
    check({tag, "_zero"},  64'(out_zero),  64'(z));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);

    // 1. Reset state, then one XOR beat
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_zero",  64'(out_zero),  64'd1);
    check("rst_ready", 64'(in_ready),  64'd1);
`ifdef BITWISE_ALU_PARITY_EN
    check("rst_par",   64'(out_par),   64'd0);
`endif
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 4'b1000, 4'b1001);
    step();
    expect_out("t1_xor", 4'b0001, 1'b0);

    // 2. Op sweep back-to-back with x=1101, y=0110
    drive(1'b1, 3'b000, 4'b1101, 4'b0110); step(); expect_out("t2_and",  4'b0100, 1'b0);
    drive(1'b1, 3'b001, 4'b1101, 4'b0110); step(); expect_out("t2_or",   4'b1111, 1'b0);
    drive(1'b1, 3'b010, 4'b1101, 4'b0110); step(); expect_out("t2_xor",  4'b1011, 1'b0);
`ifdef BITWISE_ALU_PARITY_EN
    check("t6_par_xor", 64'(out_par), 64'd1);
`endif
    drive(1'b1, 3'b011, 4'b1101, 4'b0110); step(); expect_out("t2_xnor", 4'b0100, 1'b0);
    drive(1'b1, 3'b100, 4'b1101, 4'b0110); step(); expect_out("t2_nand", 4'b1011, 1'b0);
    drive(1'b1, 3'b101, 4'b1101, 4'b0110); step(); expect_out("t2_nor",  4'b0000, 1'b1);
`ifdef BITWISE_ALU_PARITY_EN
    check("t6_par_nor", 64'(out_par), 64'd0);
`endif

    // 3. Accumulator sequence; AND in the middle must not disturb acc
    drive(1'b1, 3'b111, 4'b1111, 4'b1111); step(); expect_out("t3_clr",   4'b0000, 1'b1);
    drive(1'b1, 3'b110, 4'b1000, 4'b1001); step(); expect_out("t3_accA",  4'b0001, 1'b0);
    drive(1'b1, 3'b110, 4'b1101, 4'b0110); step(); expect_out("t3_accB",  4'b1010, 1'b0);
    drive(1'b1, 3'b000, 4'b1111, 4'b1111); step(); expect_out("t3_and",   4'b1111, 1'b0);
    drive(1'b1, 3'b110, 4'b0000, 4'b0000); step(); expect_out("t3_accC",  4'b1010, 1'b0);

    // 4. Back-pressure: ACC_XOR x=0001 held for 3 stalled cycles, then released
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    #1;
    check("t4_rdy_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("t4_stall", 4'b1010, 1'b0);
      check("t4_rdy_stall", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_rdy_high", 64'(in_ready), 64'd1);
    step();
    expect_out("t4_release", 4'b1011, 1'b0);
    drive(1'b0, 3'b110, 4'b1111, 4'b1111);
    step();
    check("t4_drain_valid", 64'(out_valid), 64'd0);
    check("t4_drain_hold",  64'(out_data),  64'(4'b1011));
    step();
    check("t4_idle_valid",  64'(out_valid), 64'd0);
    drive(1'b1, 3'b110, 4'b0000, 4'b0000); step(); expect_out("t4_acc_once", 4'b1011, 1'b0);

    // 5. Mid-stall asynchronous reset while holding 1010
    drive(1'b1, 3'b110, 4'b0001, 4'b0000); step(); expect_out("t5_fill", 4'b1010, 1'b0);
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    step();
    expect_out("t5_held", 4'b1010, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data",  64'(out_data),  64'd0);
    check("t5_rst_zero",  64'(out_zero),  64'd1);
    check("t5_rst_ready", 64'(in_ready),  64'd1);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 4'b0000, 4'b0000); step(); expect_out("t5_acc_init", 4'b0000, 1'b1);
    drive(1'b1, 3'b110, 4'b0011, 4'b0000); step(); expect_out("t5_acc_next", 4'b0011, 1'b0);
`ifdef BITWISE_ALU_PARITY_EN
    check("t6_par_even", 64'(out_par), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
